// File: rtl/adc_acq_sched_if.sv
// Scheduler-to-system signal bundle: ADC pins, detector handshake and status counters.
// master = scheduler side, slave = surrounding system / detector side.
interface adc_acq_sched_if #(
   parameter int CNT_W = 16
);
   logic             ENABLE;
   logic             ADC_OF;
   logic             EVAL_ACK;
   logic             DETECTED;
   logic [11:0]      THRESH_IN;
   logic [11:0]      THRESH_OUT;
   logic             ADC_OE_n;
   logic             SOF;
   logic             EOF;
   logic             ABORT;
   logic             EVAL_REQ;
   logic             EVAL_TO;
   logic             DETECT_LATCH;
   logic [CNT_W-1:0] FRAME_CNT;
   logic [7:0]       OVF_CNT;
   logic [7:0]       MISSED_CNT;

   modport master (
      input  ENABLE, ADC_OF, EVAL_ACK, DETECTED, THRESH_IN,
      output THRESH_OUT, ADC_OE_n, SOF, EOF, ABORT, EVAL_REQ, EVAL_TO,
             DETECT_LATCH, FRAME_CNT, OVF_CNT, MISSED_CNT
   );

   modport slave (
      output ENABLE, ADC_OF, EVAL_ACK, DETECTED, THRESH_IN,
      input  THRESH_OUT, ADC_OE_n, SOF, EOF, ABORT, EVAL_REQ, EVAL_TO,
             DETECT_LATCH, FRAME_CNT, OVF_CNT, MISSED_CNT
   );
endinterface

// File: rtl/adc_acq_sched.sv
// Periodic ADC acquisition window scheduler with detector evaluation handshake.
// Optional macro THRESH_SHADOW_EN: hold THRESH_OUT constant from SOF through evaluation.
module adc_acq_sched #(
   parameter int PERIOD_CYCLES   = 100000,
   parameter int WINDOW_CYCLES   = 100,
   parameter int OF_ABORT_CYCLES = 4,
   parameter int EVAL_TIMEOUT    = 1000,
   parameter int CNT_W           = 16
) (
   input logic             CLK_100MHz,
   input logic             SRESET_n,
   adc_acq_sched_if.master bus
);

   localparam int PW = $clog2(PERIOD_CYCLES);
   localparam int EW = (EVAL_TIMEOUT < 2) ? 1 : $clog2(EVAL_TIMEOUT);
   localparam int OW = (OF_ABORT_CYCLES < 2) ? 1 : $clog2(OF_ABORT_CYCLES);

   localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
   localparam logic [PW-1:0] WIN_LAST    = PW'(WINDOW_CYCLES - 1);
   localparam logic [EW-1:0] EVAL_LAST   = EW'(EVAL_TIMEOUT - 1);
   localparam logic [OW-1:0] OF_LAST     = (OF_ABORT_CYCLES == 0) ? '0 : OW'(OF_ABORT_CYCLES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_ACQ  = 2'd2;
   localparam logic [1:0] S_EVAL = 2'd3;

   if (PERIOD_CYCLES < 4) begin : g_bad_period
      $error("adc_acq_sched: PERIOD_CYCLES must be at least 4");
   end
   if (WINDOW_CYCLES < 1 || WINDOW_CYCLES > PERIOD_CYCLES - 2) begin : g_bad_window
      $error("adc_acq_sched: WINDOW_CYCLES must be 1..PERIOD_CYCLES-2");
   end

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    period_q, period_d;
   logic [PW-1:0]    win_q, win_d;
   logic [EW-1:0]    eval_q, eval_d;
   logic [OW-1:0]    of_run_q, of_run_d;
   logic             oe_n_q, oe_n_d;
   logic             sof_q, sof_d, eof_q, eof_d, abort_q, abort_d;
   logic             req_q, req_d, to_q, to_d, det_q, det_d;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic [7:0]       ovf_q, ovf_d, missed_q, missed_d;
   logic             fs;

   assign fs = bus.ENABLE && (period_q == '0);

   always_comb begin
      state_d  = state_q;
      period_d = '0;
      win_d    = win_q;
      eval_d   = eval_q;
      of_run_d = of_run_q;
      oe_n_d   = oe_n_q;
      sof_d    = 1'b0;
      eof_d    = 1'b0;
      abort_d  = 1'b0;
      to_d     = 1'b0;
      req_d    = req_q;
      det_d    = det_q;
      frame_d  = frame_q;
      ovf_d    = ovf_q;
      missed_d = missed_q;

      if (bus.ENABLE) begin
         period_d = (period_q == PERIOD_LAST) ? '0 : period_q + 1'b1;
      end

      // Disable is a quiet stop: no EOF/ABORT/EVAL_TO, counters and latch retained.
      if (!bus.ENABLE) begin
         state_d = S_IDLE;
         oe_n_d  = 1'b1;
         req_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ARM: begin
               if (fs) begin
                  state_d  = S_ACQ;
                  oe_n_d   = 1'b0;
                  sof_d    = 1'b1;
                  frame_d  = frame_q + 1'b1;
                  win_d    = '0;
                  of_run_d = '0;
               end
            end
            S_ACQ: begin
               of_run_d = bus.ADC_OF ? of_run_q + 1'b1 : '0;
               // Abort is tested first so it wins over a same-edge window completion.
               if ((OF_ABORT_CYCLES != 0) && bus.ADC_OF && (of_run_q == OF_LAST)) begin
                  state_d = S_ARM;
                  oe_n_d  = 1'b1;
                  abort_d = 1'b1;
                  ovf_d   = sat_inc8(ovf_q);
               end else if (win_q == WIN_LAST) begin
                  state_d = S_EVAL;
                  oe_n_d  = 1'b1;
                  eof_d   = 1'b1;
                  req_d   = 1'b1;
                  eval_d  = '0;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end
            default: begin
               if (fs) begin
                  missed_d = sat_inc8(missed_q);
               end
               if (bus.EVAL_ACK) begin
                  state_d = S_ARM;
                  det_d   = bus.DETECTED;
                  req_d   = 1'b0;
               end else if (eval_q == EVAL_LAST) begin
                  state_d = S_ARM;
                  req_d   = 1'b0;
                  to_d    = 1'b1;
               end else begin
                  eval_d = eval_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge CLK_100MHz) begin
      if (!SRESET_n) begin
         state_q  <= S_IDLE;
         period_q <= '0;
         win_q    <= '0;
         eval_q   <= '0;
         of_run_q <= '0;
         oe_n_q   <= 1'b1;
         sof_q    <= 1'b0;
         eof_q    <= 1'b0;
         abort_q  <= 1'b0;
         req_q    <= 1'b0;
         to_q     <= 1'b0;
         det_q    <= 1'b0;
         frame_q  <= '0;
         ovf_q    <= '0;
         missed_q <= '0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         win_q    <= win_d;
         eval_q   <= eval_d;
         of_run_q <= of_run_d;
         oe_n_q   <= oe_n_d;
         sof_q    <= sof_d;
         eof_q    <= eof_d;
         abort_q  <= abort_d;
         req_q    <= req_d;
         to_q     <= to_d;
         det_q    <= det_d;
         frame_q  <= frame_d;
         ovf_q    <= ovf_d;
         missed_q <= missed_d;
      end
   end

`ifdef THRESH_SHADOW_EN
   logic [11:0] thresh_q;

   always_ff @(posedge CLK_100MHz) begin
      if (!SRESET_n) begin
         thresh_q <= '0;
      end else if (fs && (state_q == S_IDLE || state_q == S_ARM)) begin
         thresh_q <= bus.THRESH_IN;
      end
   end

   assign bus.THRESH_OUT = thresh_q;
`else
   assign bus.THRESH_OUT = bus.THRESH_IN;
`endif

   assign bus.ADC_OE_n     = oe_n_q;
   assign bus.SOF          = sof_q;
   assign bus.EOF          = eof_q;
   assign bus.ABORT        = abort_q;
   assign bus.EVAL_REQ     = req_q;
   assign bus.EVAL_TO      = to_q;
   assign bus.DETECT_LATCH = det_q;
   assign bus.FRAME_CNT    = frame_q;
   assign bus.OVF_CNT      = ovf_q;
   assign bus.MISSED_CNT   = missed_q;

endmodule
